// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the RV64 pipeline core: instruction and data memories
// wrapped in a LOAD -> RUN -> DUMP -> DONE lifecycle.
module cpu_mem_responder #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned DMEM_WORDS = 1152,
  parameter int unsigned DUMP_WORDS = 1152
) (
  input  logic        clk,
  input  logic        rst,
  output logic        cpu_rst,
  input  logic [31:0] pc,
  output logic [31:0] inst,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_mem_rw,
  inout  wire  [63:0] mem_data,
  input  logic        cpu_halt,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic        ld_sel,
  input  logic [31:0] ld_addr,
  input  logic [63:0] ld_data,
  input  logic        ld_done,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [31:0] dump_addr,
  output logic [63:0] dump_data,
  output logic        dump_last,
  output logic        done,
  output logic        err_oob
);

  localparam int unsigned IA_W = $clog2(IMEM_WORDS);
  localparam int unsigned DA_W = $clog2(DMEM_WORDS);
  localparam logic [31:0] NOP  = 32'h0000_0013;

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_DUMP, S_DONE} state_t;

  state_t state, state_nxt;

  logic [31:0] imem [IMEM_WORDS];
  logic [63:0] dmem [DMEM_WORDS];

  logic [DA_W-1:0] cnt;
  logic [29:0]     pc_idx;
  logic [28:0]     d_idx;
  logic            pc_ok, d_ok, ld_ok_i, ld_ok_d;
  logic            cnt_last, accept, drive, st_en;
  logic [63:0]     rd_data, dump_first;
  logic            unused_bits;

  // Address decode; anything at or beyond the array depth is out of range
  assign pc_idx   = pc[31:2];
  assign d_idx    = cpu_addr[31:3];
  assign pc_ok    = pc_idx < 30'(IMEM_WORDS);
  assign d_ok     = d_idx < 29'(DMEM_WORDS);
  assign ld_ok_i  = ld_addr < 32'(IMEM_WORDS);
  assign ld_ok_d  = ld_addr < 32'(DMEM_WORDS);
  assign cnt_last = cnt == DA_W'(DUMP_WORDS - 1);
  assign accept   = dump_valid && dump_ready;
  assign st_en    = (state == S_RUN) && cpu_mem_rw && d_ok;
  assign rd_data  = d_ok ? dmem[d_idx[DA_W-1:0]] : 64'h0;
  assign unused_bits = ^{pc[1:0], cpu_addr[2:0]};

  assign mem_data  = drive ? rd_data : {64{1'bz}};
  assign dump_addr = 32'(cnt);

  // First dump beat is captured on the halt edge, so a same-cycle store to word 0 is forwarded
  assign dump_first = (st_en && d_idx == 29'd0) ? mem_data : dmem[0];

  always_ff @(posedge clk) begin
    if (rst) state <= S_LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cpu_rst    = 1'b0;
    ld_ready   = 1'b0;
    inst       = 32'h0;
    drive      = 1'b0;
    dump_valid = 1'b0;
    dump_last  = 1'b0;
    done       = 1'b0;
    case (state)
      S_LOAD: begin
        cpu_rst  = 1'b1;
        ld_ready = 1'b1;
        inst     = NOP;
        if (ld_done) state_nxt = S_RUN;
      end
      S_RUN: begin
        inst  = pc_ok ? imem[pc_idx[IA_W-1:0]] : 32'h0;
        drive = !cpu_mem_rw;
        if (cpu_halt) state_nxt = S_DUMP;
      end
      S_DUMP: begin
        dump_valid = 1'b1;
        dump_last  = cnt_last;
        if (dump_ready && cnt_last) state_nxt = S_DONE;
      end
      S_DONE: done = 1'b1;
      default: state_nxt = S_LOAD;
    endcase
  end

  // Memory arrays: loader writes in LOAD, core stores in RUN; contents survive reset
  always_ff @(posedge clk) begin
    if (state == S_LOAD && ld_valid) begin
      if (!ld_sel && ld_ok_i) imem[ld_addr[IA_W-1:0]] <= ld_data[31:0];
      if (ld_sel && ld_ok_d)  dmem[ld_addr[DA_W-1:0]] <= ld_data;
    end else if (st_en) begin
      dmem[d_idx[DA_W-1:0]] <= mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      dump_data <= 64'h0;
      err_oob   <= 1'b0;
    end else begin
      if (state == S_RUN && !d_ok) err_oob <= 1'b1;
      if (state == S_RUN && cpu_halt) begin
        cnt       <= '0;
        dump_data <= dump_first;
      end else if (accept && !cnt_last) begin
        cnt       <= cnt + DA_W'(1);
        dump_data <= dmem[cnt + DA_W'(1)];
      end
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Randomized self-checking bench for cpu_mem_responder against an array-based reference model.
module tb_cpu_mem_responder;

  localparam int unsigned IW  = 256;
  localparam int unsigned DW  = 1152;
  localparam int unsigned DPW = 8;

  logic        clk = 1'b0;
  logic        rst, cpu_rst, cpu_mem_rw, cpu_halt;
  logic [31:0] pc, inst, cpu_addr;
  logic        ld_valid, ld_ready, ld_sel, ld_done;
  logic [31:0] ld_addr;
  logic [63:0] ld_data;
  logic        dump_valid, dump_ready, dump_last, done, err_oob;
  logic [31:0] dump_addr;
  logic [63:0] dump_data;
  logic        tb_drive;
  logic [63:0] tb_data;
  wire  [63:0] mem_data;

  assign mem_data = tb_drive ? tb_data : {64{1'bz}};

  cpu_mem_responder #(.IMEM_WORDS(IW), .DMEM_WORDS(DW), .DUMP_WORDS(DPW)) dut (
    .clk(clk), .rst(rst), .cpu_rst(cpu_rst), .pc(pc), .inst(inst),
    .cpu_addr(cpu_addr), .cpu_mem_rw(cpu_mem_rw), .mem_data(mem_data),
    .cpu_halt(cpu_halt), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data), .ld_done(ld_done),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
    .dump_data(dump_data), .dump_last(dump_last), .done(done), .err_oob(err_oob)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // Reference model: plain arrays updated by the rules of each lifecycle phase
  logic [31:0] imem_m [IW];
  logic [63:0] dmem_m [DW];
  logic        err_m;

  int unsigned w, pw;
  logic        st;
  int          beats;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld_beat(input logic sel, input logic [31:0] a, input logic [63:0] d);
    ld_valid = 1'b1; ld_sel = sel; ld_addr = a; ld_data = d;
    tick();
    ld_valid = 1'b0;
    if (!sel && a < IW) imem_m[a] = d[31:0];
    if (sel && a < DW)  dmem_m[a] = d;
  endtask

  // Dump with dump_ready toggling 1,0,1,...; stops early once stop_at beats are accepted
  task automatic do_dump(input int stop_at, output int n);
    int k;
    k = 0;
    n = 0;
    for (int c = 0; c < 64 && k < int'(DPW) && k != stop_at; c++) begin
      dump_ready = (c % 2 == 0);
      #1;
      chk("dump_valid", 64'(dump_valid), 64'd1);
      chk("dump_addr", 64'(dump_addr), 64'(k));
      chk("dump_data", dump_data, dmem_m[k]);
      chk("dump_last", 64'(dump_last), 64'(k == int'(DPW) - 1));
      chk("done_low", 64'(done), 64'd0);
      if (dump_ready) begin
        k++;
        n++;
      end
      tick();
    end
    dump_ready = 1'b0;
  endtask

  task automatic halt_core();
    cpu_halt = 1'b1;
    tick();
    cpu_halt = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pc = 32'd4; cpu_addr = 32'd0; cpu_mem_rw = 1'b0; cpu_halt = 1'b0;
    ld_valid = 1'b0; ld_sel = 1'b0; ld_addr = 32'd0; ld_data = 64'd0; ld_done = 1'b0;
    dump_ready = 1'b0; tb_drive = 1'b0; tb_data = 64'd0; err_m = 1'b0;
    tick(); tick();
    chk("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("rst_ld_ready", 64'(ld_ready), 64'd1);
    chk("rst_inst", 64'(inst), 64'h13);
    chk("rst_dump_valid", 64'(dump_valid), 64'd0);
    chk("rst_dump_addr", 64'(dump_addr), 64'd0);
    chk("rst_dump_data", dump_data, 64'd0);
    chk("rst_dump_last", 64'(dump_last), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err_oob", 64'(err_oob), 64'd0);
    rst = 1'b0;

    // Preload: program words, random filler, random data, and dropped out-of-range beats
    ld_beat(1'b0, 32'd0, 64'h0050_0093);
    ld_beat(1'b0, 32'd1, 64'h0210_3423);
    ld_beat(1'b0, 32'd2, 64'h0280_3103);
    ld_beat(1'b0, 32'd3, 64'h0000_006F);
    for (int i = 4; i < 16; i++) ld_beat(1'b0, 32'(i), {32'd0, $urandom});
    for (int i = 0; i < 64; i++) ld_beat(1'b1, 32'(i), {$urandom, $urandom});
    ld_beat(1'b1, 32'd5, 64'hDEAD_BEEF_0000_0001);
    ld_beat(1'b0, 32'd256, 64'hFFFF_FFFF);
    ld_beat(1'b1, 32'd1152, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("load_inst_nop", 64'(inst), 64'h13);
    chk("load_ld_ready", 64'(ld_ready), 64'd1);

    ld_done = 1'b1;
    #1;
    chk("ld_done_cpu_rst_still", 64'(cpu_rst), 64'd1);
    tick();
    ld_done = 1'b0;
    chk("run_cpu_rst", 64'(cpu_rst), 64'd0);
    chk("run_ld_ready", 64'(ld_ready), 64'd0);
    chk("run_inst_pc4", 64'(inst), 64'(imem_m[1]));
    pc = 32'd0; #1;
    chk("run_inst_pc0", 64'(inst), 64'(imem_m[0]));
    pc = 32'd1024; #1;
    chk("run_inst_oob", 64'(inst), 64'd0);

    // Store then load the same word on the next cycle
    cpu_mem_rw = 1'b1; cpu_addr = 32'd40; tb_drive = 1'b1; tb_data = 64'h1234;
    #1;
    chk("store_bus", mem_data, 64'h1234);
    tick();
    dmem_m[5] = 64'h1234;
    cpu_mem_rw = 1'b0; tb_drive = 1'b0;
    #1;
    chk("load_after_store", mem_data, 64'h1234);
    chk("err_oob_clean", 64'(err_oob), 64'd0);

    // Randomized loads, stores and fetches
    for (int i = 0; i < 80; i++) begin
      w  = $urandom_range(0, 63);
      st = 1'($urandom_range(0, 1));
      pw = $urandom_range(0, 19);
      pc = (pw < 16) ? (pw * 4 + $urandom_range(0, 3)) : ((256 + $urandom_range(0, 1000)) * 4);
      cpu_addr = w * 8 + $urandom_range(0, 7);
      if (st) begin
        tb_data = {$urandom, $urandom}; tb_drive = 1'b1; cpu_mem_rw = 1'b1;
        #1;
        chk("rand_store_bus", mem_data, tb_data);
      end else begin
        #1;
        chk("rand_load", mem_data, dmem_m[w]);
      end
      chk("rand_inst", 64'(inst), (pw < 16) ? 64'(imem_m[pw]) : 64'd0);
      tick();
      if (st) dmem_m[w] = tb_data;
      tb_drive = 1'b0; cpu_mem_rw = 1'b0;
    end

    // Out-of-range load sets sticky error
    cpu_addr = 32'd9216;
    #1;
    chk("oob_load_zero", mem_data, 64'd0);
    tick();
    err_m = 1'b1;
    cpu_addr = 32'd8;
    chk("oob_err_set", 64'(err_oob), 64'(err_m));
    tick();
    chk("oob_err_sticky", 64'(err_oob), 64'(err_m));

    // Halt with a same-cycle store to word 0
    pc = 32'd4; cpu_addr = 32'd0; cpu_mem_rw = 1'b1; tb_drive = 1'b1; tb_data = 64'hA5A5_5A5A_0F0F_F0F0;
    halt_core();
    dmem_m[0] = tb_data;
    cpu_mem_rw = 1'b0; tb_drive = 1'b0;
    chk("dump_inst_zero", 64'(inst), 64'd0);
    do_dump(-1, beats);
    chk("dump_beats", 64'(beats), 64'(DPW));
    chk("done_high", 64'(done), 64'd1);
    chk("done_no_valid", 64'(dump_valid), 64'd0);
    chk("done_cpu_rst", 64'(cpu_rst), 64'd0);
    tick();
    chk("done_hold", 64'(done), 64'd1);

    // Second run: reset in the middle of the dump
    rst = 1'b1; tick(); rst = 1'b0; err_m = 1'b0;
    ld_done = 1'b1; tick(); ld_done = 1'b0;
    halt_core();
    do_dump(3, beats);
    chk("mid_dump_addr", 64'(dump_addr), 64'd3);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_err", 64'(err_oob), 64'(err_m));
    chk("mid_rst_valid", 64'(dump_valid), 64'd0);
    ld_done = 1'b1; tick(); ld_done = 1'b0;
    halt_core();
    do_dump(-1, beats);
    chk("redump_beats", 64'(beats), 64'(DPW));
    chk("redump_done", 64'(done), 64'd1);

    // Beat coinciding with ld_done is still written
    rst = 1'b1; tick(); rst = 1'b0;
    ld_valid = 1'b1; ld_sel = 1'b1; ld_addr = 32'd2; ld_data = 64'd7; ld_done = 1'b1;
    tick();
    ld_valid = 1'b0; ld_done = 1'b0; dmem_m[2] = 64'd7;
    chk("same_cycle_run", 64'(cpu_rst), 64'd0);
    cpu_addr = 32'd16;
    #1;
    chk("same_cycle_load", mem_data, dmem_m[2]);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
